// File: rtl/hilo_ctrl.sv
// HI/LO special-register sequencer: accepts mul/div/move ops from decode, drives the
// external multiply/divide unit, then writes HI/LO while stalling dependent decode.
module hilo_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    output logic        stall,
    output logic        md_start,
    output logic        md_signed,
    output logic        md_is_div,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_done,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        hi_ena,
    output logic        lo_ena,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [7:0] TMO      = 8'(TIMEOUT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        md_start_q, md_start_d;
    logic        md_signed_q, md_signed_d;
    logic        md_is_div_q, md_is_div_d;
    logic [31:0] md_a_q, md_a_d;
    logic [31:0] md_b_q, md_b_d;
    logic        hi_ena_q, hi_ena_d;
    logic        lo_ena_q, lo_ena_d;
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic [31:0] lo_wdata_q, lo_wdata_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            md_start_q  <= 1'b0;
            md_signed_q <= 1'b0;
            md_is_div_q <= 1'b0;
            md_a_q      <= '0;
            md_b_q      <= '0;
            hi_ena_q    <= 1'b0;
            lo_ena_q    <= 1'b0;
            hi_wdata_q  <= '0;
            lo_wdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_start_q  <= md_start_d;
            md_signed_q <= md_signed_d;
            md_is_div_q <= md_is_div_d;
            md_a_q      <= md_a_d;
            md_b_q      <= md_b_d;
            hi_ena_q    <= hi_ena_d;
            lo_ena_q    <= lo_ena_d;
            hi_wdata_q  <= hi_wdata_d;
            lo_wdata_q  <= lo_wdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_start_d  = 1'b0;
        md_signed_d = md_signed_q;
        md_is_div_d = md_is_div_q;
        md_a_d      = md_a_q;
        md_b_d      = md_b_q;
        hi_ena_d    = 1'b0;
        lo_ena_d    = 1'b0;
        hi_wdata_d  = hi_wdata_q;
        lo_wdata_d  = lo_wdata_q;
        err_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d     = S_WAIT;
                            cnt_d       = '0;
                            md_start_d  = 1'b1;
                            md_signed_d = (op == OP_MULT);
                            md_is_div_d = 1'b0;
                            md_a_d      = rs_val;
                            md_b_d      = rt_val;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Zero divisor never reaches the unit; it only raises err.
                            if (rt_val == '0) begin
                                err_d = 1'b1;
                            end else begin
                                state_d     = S_WAIT;
                                cnt_d       = '0;
                                md_start_d  = 1'b1;
                                md_signed_d = (op == OP_DIV);
                                md_is_div_d = 1'b1;
                                md_a_d      = rs_val;
                                md_b_d      = rt_val;
                            end
                        end
                        OP_MTHI: begin
                            state_d    = S_WRITE;
                            hi_ena_d   = 1'b1;
                            hi_wdata_d = rs_val;
                        end
                        OP_MTLO: begin
                            state_d    = S_WRITE;
                            lo_ena_d   = 1'b1;
                            lo_wdata_d = rs_val;
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT: begin
                // md_start_q marks the first WAIT cycle, where md_done is not trusted.
                if (!md_start_q && md_done) begin
                    state_d    = S_WRITE;
                    hi_ena_d   = 1'b1;
                    lo_ena_d   = 1'b1;
                    hi_wdata_d = md_hi;
                    lo_wdata_d = md_lo;
                end else if (cnt_q >= TMO_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = TMO;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign stall     = busy & (op_valid | mf_req);
    assign md_start  = md_start_q;
    assign md_signed = md_signed_q;
    assign md_is_div = md_is_div_q;
    assign md_a      = md_a_q;
    assign md_b      = md_b_q;
    assign hi_ena    = hi_ena_q;
    assign lo_ena    = lo_ena_q;
    assign hi_wdata  = hi_wdata_q;
    assign lo_wdata  = lo_wdata_q;
    assign err       = err_q;

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencer for the CPU's HI and LO special registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from decode, starts the external multi-cycle multiply/divide unit, and waits for its result. It then drives the write-enable and data inputs of the HI and LO register instances, and stalls decode while a HI/LO producer is in flight so MFHI/MFLO never read stale data.

## Interface
Parameters:
- TIMEOUT, 64, maximum cycles spent waiting for md_done before the operation is aborted (legal range 2..255).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- op_valid  in  1  decode presents an op this cycle.
- op  in  3  opcode: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- rs_val  in  32  rs operand (dividend/multiplicand, or MTHI/MTLO data).
- rt_val  in  32  rt operand (divisor/multiplier).
- mf_req  in  1  decode holds an MFHI/MFLO this cycle.
- stall  out  1  combinational; decode must hold op/mf_req while high.
- md_start  out  1  one-cycle start pulse to the mul/div unit.
- md_signed  out  1  1 for MULT/DIV, 0 for MULTU/DIVU.
- md_is_div  out  1  1 for DIV/DIVU.
- md_a, md_b  out  32 each  latched rs_val, rt_val.
- md_done  in  1  mul/div result valid (single-cycle pulse).
- md_hi, md_lo  in  32 each  mul/div result halves.
- hi_ena, lo_ena  out  1 each  write enables to the HI and LO registers.
- hi_wdata, lo_wdata  out  32 each  write data to the HI and LO registers.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on divide-by-zero or timeout.

## Operation
States:
- **IDLE:** default state. An op is accepted when op_valid=1 and stall=0.
  - MULT/MULTU: latch operands and sign into md_a/md_b/md_signed, clear md_is_div, go to WAIT.
  - DIV/DIVU with rt_val≠0: as above, with md_is_div=1.
  - DIV/DIVU with rt_val=0: do not start the unit, do not write HI/LO, pulse err next cycle, stay in IDLE.
  - MTHI: hi_wdata←rs_val, go to WRITE with only HI enabled.
  - MTLO: lo_wdata←rs_val, go to WRITE with only LO enabled.
  - NOP or reserved op: accepted, no effect.
- **WAIT:**
  - md_start=1 in the first WAIT cycle only; the timeout counter clears on entry.
  - md_done is sampled from the second WAIT cycle onward. When md_done=1: hi_wdata←md_hi, lo_wdata←md_lo, go to WRITE with both enabled.
  - md_done asserted in the md_start cycle, or in any IDLE or WRITE cycle, is ignored.
  - When the counter reaches TIMEOUT without md_done: go to IDLE, pulse err, no write.
- **WRITE:** exactly one cycle. The selected hi_ena/lo_ena are 1 and the wdata outputs are stable. Then go to IDLE.

Output and width rules:
- stall = busy & (op_valid | mf_req). stall is always 0 in IDLE.
- All outputs except stall and busy are registered.
- hi_ena and lo_ena are 1 only in WRITE.
- hi_wdata, lo_wdata, md_a, md_b hold their last value when not being updated.
- Counter width is 8 bits and does not wrap. The count saturates at TIMEOUT.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, counter=0. All outputs are 0: md_start, md_signed, md_is_div, md_a, md_b, hi_ena, lo_ena, hi_wdata, lo_wdata, busy, err.
- Reset while in WAIT or WRITE aborts the operation: no HI/LO write occurs after reset release.
- MTHI/MTLO: accepted at edge N. WRITE is during cycle N+1. IDLE at N+2. An MFHI/MFLO in cycle N+1 is stalled; the first non-stalled read is in cycle N+2.
- MULT/DIV: accepted at edge N. md_start is high in cycle N+1. md_done is first seen at cycle N+1+k (k≥1). WRITE is in cycle N+2+k. IDLE in cycle N+3+k.
- An op_valid arriving in WAIT or WRITE is stalled and accepted in the first IDLE cycle. There is no back-to-back acceptance across WRITE.
- Divide-by-zero: err is high in cycle N+1 and stall stays 0, so decode may issue its next op in cycle N+1.
- Timeout: err is high in the cycle after the counter hits TIMEOUT; busy falls the same cycle.

## Test plan
- MTHI with rs_val=0x12345678, then MFHI the next cycle:
  - hi_ena=1 with hi_wdata=0x12345678 one cycle after accept; lo_ena=0.
  - stall=1 for mf_req during WRITE; MFHI is released one cycle later.
- MULT with rs_val=0xFFFFFFFE, rt_val=3, unit model returns done after 5 cycles with hi=0xFFFFFFFF, lo=0xFFFFFFFA:
  - md_signed=1, md_is_div=0, one md_start pulse.
  - Both enables are high for exactly one cycle with those values.
- DIVU with rs_val=100, rt_val=7, model done after 32 cycles with hi=2, lo=14:
  - md_is_div=1, md_signed=0.
  - stall stays high for op_valid and mf_req during the whole wait; the write occurs after done.
- DIV with rt_val=0:
  - No md_start, no enables, err high one cycle, busy never rises.
- Timeout with TIMEOUT=8 and a model that never raises done:
  - err pulses once and state returns to IDLE.
  - HI/LO enables never assert; a later MULT completes normally.
- Reset mid-operation:
  - Drive rst=0 during WAIT, then md_done after release.
  - All outputs are 0 immediately; the stale md_done is ignored and no write occurs.
